// File: rtl/cpu_pipe_pkg.sv
//==============================================================================
// Module  : cpu_pipe_pkg
// Brief   : Shared control-bundle layout and bubble encoding for pipeline stages.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_pipe_pkg;

  localparam int CTRL_W = 8;

  localparam logic [3:0] OPC_NOP = 4'b0100;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_OPC_LSB  = 4;
  // The 8-bit bundle is too narrow for separate branch/halt bits, so they alias
  // the low opcode bits; the NOP opcode leaves both clear.
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_HALT     = 5;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(OPC_NOP) << CTRL_OPC_LSB;

endpackage

`default_nettype wire

// File: rtl/pipe_entry_reg.sv
//==============================================================================
// Module  : pipe_entry_reg
// Brief   : One valid+ctrl+data pipeline entry with load/clear and async reset.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_entry_reg #(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 64,
  parameter logic [CTRL_W-1:0] RST_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clear leaves data untouched: it is unobservable once valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= RST_CTRL;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= RST_CTRL;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//==============================================================================
// Module  : pipe_stage_reg
// Brief   : Parametrised valid/ready pipeline-stage register with optional skid
//           entry, synchronous flush and NOP-bubble control output.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int                CTRL_W      = cpu_pipe_pkg::CTRL_W,
  parameter int                DATA_W      = 64,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(OPC_NOP) << CTRL_OPC_LSB,
  parameter bit                SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_m_load;
  logic              w_m_in_valid;
  logic [CTRL_W-1:0] w_m_in_ctrl;
  logic [DATA_W-1:0] w_m_in_data;
  logic              w_m_valid;
  logic [CTRL_W-1:0] w_m_ctrl;
  logic [DATA_W-1:0] w_m_data;
  logic              w_s_valid;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_m_valid & out_ready;

  pipe_entry_reg #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .RST_CTRL (BUBBLE_CTRL)
  ) u_m (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_m_load),
    .i_clear (flush),
    .i_valid (w_m_in_valid),
    .i_ctrl  (w_m_in_ctrl),
    .i_data  (w_m_in_data),
    .o_valid (w_m_valid),
    .o_ctrl  (w_m_ctrl),
    .o_data  (w_m_data)
  );

  generate
    if (SKID) begin : g_skid
      logic              w_s_load;
      logic [CTRL_W-1:0] w_s_ctrl;
      logic [DATA_W-1:0] w_s_data;

      // S only fills while M is stalled; it drains whenever M reloads, and
      // in_ready is low while it is full, so input and drain never coincide.
      assign w_m_load     = !w_m_valid | w_out_fire;
      assign w_s_load     = (w_m_load & w_s_valid) | (w_m_valid & !w_out_fire & w_in_fire);
      assign w_m_in_valid = w_s_valid | w_in_fire;
      assign w_m_in_ctrl  = w_s_valid ? w_s_ctrl : in_ctrl;
      assign w_m_in_data  = w_s_valid ? w_s_data : in_data;
      assign in_ready     = !w_s_valid;

      pipe_entry_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .RST_CTRL (BUBBLE_CTRL)
      ) u_s (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s_load),
        .i_clear (flush),
        .i_valid (w_in_fire),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_s_valid),
        .o_ctrl  (w_s_ctrl),
        .o_data  (w_s_data)
      );
    end else begin : g_noskid
      assign w_m_load     = w_in_fire | w_out_fire;
      assign w_m_in_valid = w_in_fire;
      assign w_m_in_ctrl  = in_ctrl;
      assign w_m_in_data  = in_data;
      assign in_ready     = !w_m_valid | out_ready;
      assign w_s_valid    = 1'b0;
    end
  endgenerate

  assign out_valid = w_m_valid;
  assign out_ctrl  = w_m_valid ? w_m_ctrl : BUBBLE_CTRL;
  assign out_data  = w_m_data;
  assign occupancy = {1'b0, w_m_valid} + {1'b0, w_s_valid};

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline-stage register. It is the successor to the per-stage hand-written IF/ID, ID/EX, EX/MEM and MEM/WB flip-flop banks.
- Carries a control bundle and a data bundle of configurable width between two stages.
- Uses a valid/ready handshake with an optional 2-entry skid buffer.
- Provides synchronous flush (bubble insertion) for branch/hazard squashing.
- Drives a NOP control encoding whenever the stage holds no valid instruction.

Parameters:
CTRL_W, 8, width of control bundle (RegWrite, MemRead, MemWrite, MemtoReg, Branch, halt, opcode…)
DATA_W, 64, width of data bundle (ALU result, register values, register indices, pc_inc, imm)
BUBBLE_CTRL, {CTRL_W{1'b0}} with opcode field 4'b0100, control value presented when the stage is empty or flushed
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream stage holds a valid entry
in_ready  output  1  this stage can accept an entry this cycle
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
flush  input  1  synchronous squash of all held entries and of any entry offered this cycle
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream stage accepts this cycle (tie 1 when the downstream stage never stalls)
out_ctrl  output  CTRL_W  control to downstream; equals BUBBLE_CTRL when out_valid=0
out_data  output  DATA_W  data to downstream
occupancy  output  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- The clock is one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async assert, sync release):
  - m_valid=0, s_valid=0, m_ctrl=s_ctrl=BUBBLE_CTRL, m_data=s_data=0.
  - Resulting outputs: out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0, in_ready=1.
  - Inputs are ignored while rst=1.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid may drop without a transfer (no upstream hold obligation).
  - Held outputs are stable while out_valid=1 & out_ready=0.
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle). There is no combinational in→out path.
- out_valid = m_valid. out_ctrl = m_valid ? m_ctrl : BUBBLE_CTRL. out_data = m_data.
- SKID=1:
  - in_ready = !s_valid (registered).
  - Main register M is next-loaded when !m_valid | out_fire. It loads from S if s_valid, otherwise from input if in_fire, otherwise it becomes empty.
  - When M is full & !out_fire & in_fire, the entry goes to S.
  - S empties when M loads from it.
  - Simultaneous in_fire & out_fire with S empty: M replaced, occupancy unchanged.
  - Simultaneous in_fire & out_fire with S full: cannot occur (in_ready=0).
  - Order is strictly FIFO.
- SKID=0:
  - in_ready = !m_valid | out_ready (combinational).
  - M loads on in_fire, empties on out_fire without in_fire.
  - s_* are unused (optimised away).
- Flush (synchronous, highest priority over all events):
  - m_valid=s_valid=0 and ctrl registers set to BUBBLE_CTRL at the next edge.
  - An entry offered with in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed downstream.
  - Data registers are left unchanged, which is don't-care since out_valid=0.
- Flush and rst together: rst wins.
- Reset asserted mid-transfer: all entries are lost, and outputs go to reset values immediately (asynchronously).
- occupancy = m_valid + s_valid (2-bit, no wrap). It never exceeds 2.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - the OPC_NOP = 4'b0100 constant;
  - bit-position constants for the control bundle (CTRL_REGWRITE, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_MEMTOREG, CTRL_BRANCH, CTRL_HALT, CTRL_OPC_LSB);
  - the CTRL_W constant;
  - the derived BUBBLE_CTRL value.
- One natural sub-module: pipe_entry_reg, a single valid+ctrl+data register with load/clear enables and async reset. It is instantiated as M and S.

Test Plan:
- Reset: assert rst mid-cycle with M and S full → out_valid=0, out_ctrl=BUBBLE_CTRL (opcode 4'b0100), occupancy=0 before the next edge; in_ready=1 after release.
- Streaming: SKID=1, out_ready=1, push ctrl/data 0x11/0xA0..0xA7 on 8 consecutive cycles → the same sequence appears on out_* one cycle later, 1 per cycle; occupancy stays 1.
- Stall/skid: out_ready=0 while pushing 0xB0, 0xB1, 0xB2 → 0xB0 in M, 0xB1 in S, in_ready=0 and 0xB2 held upstream; raise out_ready → out emits 0xB0, 0xB1, 0xB2 in order, no loss or duplicate.
- Flush: M=0xC0, S=0xC1, in_valid with 0xC2, flush=1 for one cycle → next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0; 0xC2 never appears.
- SKID=0: out_ready=0 with M full → in_ready=0 in the same cycle; out_ready=1 & in_valid → in_ready=1 combinationally and M replaced in one edge.
- Randomised backpressure (1000 cycles, 50% in_valid/out_ready) against a scoreboard queue → exact in-order match; occupancy never exceeds 2.
